// File: rtl/core_mem_port_arbiter.sv
// Arbitrates the core's single memory port between instruction fetch and the
// load/store unit; an order queue routes in-order read responses to their requester.
module core_mem_port_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iFETCH_REQ,
  input  logic [31:0] iFETCH_ADDR,
  output logic        oFETCH_LOCK,
  input  logic        iFETCH_FLUSH,
  output logic        oFETCH_VALID,
  output logic [31:0] oFETCH_DATA,
  input  logic        iDATA_REQ,
  input  logic        iDATA_RW,
  input  logic [31:0] iDATA_ADDR,
  input  logic [31:0] iDATA_WDATA,
  input  logic [3:0]  iDATA_MASK,
  output logic        oDATA_LOCK,
  output logic        oDATA_VALID,
  output logic [31:0] oDATA_RDATA,
  output logic        oMEM_REQ,
  input  logic        iMEM_LOCK,
  output logic        oMEM_RW,
  output logic [31:0] oMEM_ADDR,
  output logic [31:0] oMEM_WDATA,
  output logic [3:0]  oMEM_MASK,
  input  logic        iMEM_VALID,
  input  logic [31:0] iMEM_DATA,
  output logic        oPROTOCOL_ERR
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [AW:0]       wp, rp, count;
  logic [DEPTH-1:0]  q_src, q_disc, fetch_live;
  logic [SW-1:0]     starve;
  logic [AW-1:0]     off, head;
  logic              full, starved, fetch_elig, data_elig;
  logic              grant_fetch, grant_data, fetch_acc, data_acc;
  logic              push, pop, head_src, head_disc;

  always_comb begin
    count       = wp - rp;
    full        = (count == (AW+1)'(DEPTH));
    starved     = (starve == SW'(STARVE_LIMIT));
    fetch_elig  = iFETCH_REQ && !iFETCH_FLUSH && !full;
    data_elig   = iDATA_REQ && (iDATA_RW || !full);
    grant_fetch = !iRESET_SYNC && fetch_elig && (!data_elig || starved);
    grant_data  = !iRESET_SYNC && data_elig && !grant_fetch;
    fetch_acc   = grant_fetch && !iMEM_LOCK;
    data_acc    = grant_data && !iMEM_LOCK;
    push        = fetch_acc || (data_acc && !iDATA_RW);
    pop         = iMEM_VALID && (count != '0);
    head        = rp[AW-1:0];
    head_src    = q_src[head];
    // A flush in the pop cycle must also drop the response being popped.
    head_disc   = q_disc[head] || iFETCH_FLUSH;
  end

  // Mark which slots hold live fetch entries so a flush can tag them all.
  always_comb begin
    fetch_live = '0;
    off        = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off           = AW'(i) - rp[AW-1:0];
      fetch_live[i] = ({1'b0, off} < count) && !q_src[i];
    end
  end

  always_comb begin
    oFETCH_LOCK = !fetch_acc;
    oDATA_LOCK  = !data_acc;
    oMEM_REQ    = grant_fetch || grant_data;
    oMEM_RW     = 1'b0;
    oMEM_ADDR   = '0;
    oMEM_WDATA  = '0;
    oMEM_MASK   = '0;
    if (grant_fetch) begin
      oMEM_ADDR = iFETCH_ADDR & 32'hFFFF_FFFC;
      oMEM_MASK = '1;
    end else if (grant_data) begin
      oMEM_RW    = iDATA_RW;
      oMEM_ADDR  = iDATA_ADDR;
      oMEM_WDATA = iDATA_WDATA;
      oMEM_MASK  = iDATA_MASK;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      wp            <= '0;
      rp            <= '0;
      q_src         <= '0;
      q_disc        <= '0;
      starve        <= '0;
      oFETCH_VALID  <= 1'b0;
      oFETCH_DATA   <= '0;
      oDATA_VALID   <= 1'b0;
      oDATA_RDATA   <= '0;
      oPROTOCOL_ERR <= 1'b0;
    end else begin
      // Flush first so a same-cycle push overrides its own slot's discard bit.
      if (iFETCH_FLUSH)
        q_disc <= q_disc | fetch_live;
      if (push) begin
        q_src[wp[AW-1:0]]  <= data_acc;
        q_disc[wp[AW-1:0]] <= 1'b0;
        wp                 <= wp + (AW+1)'(1);
      end
      if (pop)
        rp <= rp + (AW+1)'(1);

      oFETCH_VALID <= pop && !head_src && !head_disc;
      oDATA_VALID  <= pop && head_src;
      if (pop && !head_src && !head_disc)
        oFETCH_DATA <= iMEM_DATA;
      if (pop && head_src)
        oDATA_RDATA <= iMEM_DATA;
      if (iMEM_VALID && count == '0)
        oPROTOCOL_ERR <= 1'b1;

      if (fetch_acc)
        starve <= '0;
      else if (iFETCH_REQ && !starved)
        starve <= starve + SW'(1);
    end
  end
endmodule
